// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and port-slice helpers for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;
   localparam int DEPTH      = 2 ** ADDR_W_DEF;

   // Low bit of read port 'port' inside the packed rd_addr vector.
   function automatic int unsigned addr_lsb(input int unsigned port, input int unsigned addr_w);
      return port * addr_w;
   endfunction

   // Low bit of read port 'port' inside the packed rd_data vector.
   function automatic int unsigned data_lsb(input int unsigned port, input int unsigned data_w);
      return port * data_w;
   endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bus of the register file: write port, read ports and scoreboard.
interface regfile_mp_sb_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF
);

   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     sb_set;
   logic [ADDR_W-1:0]        sb_set_addr;
   logic [ADDR_W:0]          busy_cnt;

   // Pipeline side: drives writes, read addresses and issue.
   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_set_addr,
      input  rd_data, rd_busy, busy_cnt
   );

   // Register file side.
   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_set_addr,
      output rd_data, rd_busy, busy_cnt
   );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, set wins on a collision.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int ZERO_R0 = 1
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic                  sb_set,
   input  logic [ADDR_W-1:0]     sb_set_addr,
   output logic [2**ADDR_W-1:0]  busy,
   output logic [ADDR_W:0]       busy_cnt
);

   localparam int SB_DEPTH = 2 ** ADDR_W;

   logic [SB_DEPTH-1:0] busy_reg, busy_next;
   logic [ADDR_W:0]     cnt_reg, cnt_next;
   logic                wr_ok, set_ok, rise, fall;

   // r0 never becomes busy and never needs clearing when it is hardwired.
   assign wr_ok  = wr_en  && ((wr_addr     != '0) || (ZERO_R0 == 0));
   assign set_ok = sb_set && ((sb_set_addr != '0) || (ZERO_R0 == 0));

   // Next busy vector and the net count change; the set is applied last so it wins.
   always_comb begin
      busy_next = busy_reg;
      if (wr_ok)  busy_next[wr_addr]     = 1'b0;
      if (set_ok) busy_next[sb_set_addr] = 1'b1;
      rise     = set_ok && !busy_reg[sb_set_addr];
      fall     = wr_ok && busy_reg[wr_addr] && !(set_ok && (sb_set_addr == wr_addr));
      cnt_next = cnt_reg + {{ADDR_W{1'b0}}, rise} - {{ADDR_W{1'b0}}, fall};
   end

   // Busy bits and population count, cleared on reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         busy_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         busy_reg <= busy_next;
         cnt_reg  <= cnt_next;
      end
   end

   assign busy     = busy_reg;
   assign busy_cnt = cnt_reg;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with r0 rule, write-to-read bypass and scoreboard.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int NUM_RD  = NUM_RD_DEF,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic            CLK,
   input  logic            Reset,
   regfile_mp_sb_if.slave  bus
);

   localparam int RF_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]   rf_reg [RF_DEPTH];
   logic [RF_DEPTH-1:0] busy;
   logic                wr_ok;

   assign wr_ok = bus.wr_en && ((bus.wr_addr != '0) || (ZERO_R0 == 0));

   // Storage: whole array cleared on reset, otherwise one legal write per cycle.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < RF_DEPTH; i++) rf_reg[i] <= '0;
      end else if (wr_ok) begin
         rf_reg[bus.wr_addr] <= bus.wr_data;
      end
   end

   rf_scoreboard #(
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
   ) u_sb (
      .CLK         (CLK),
      .Reset       (Reset),
      .wr_en       (bus.wr_en),
      .wr_addr     (bus.wr_addr),
      .sb_set      (bus.sb_set),
      .sb_set_addr (bus.sb_set_addr),
      .busy        (busy),
      .busy_cnt    (bus.busy_cnt)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] val;
         logic              hit;

         assign addr = bus.rd_addr[addr_lsb(gi, ADDR_W) +: ADDR_W];
         // A same-cycle write to this port's register forwards its data, except during reset.
         assign hit  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == addr) && !Reset;

         // Read mux: array, then bypass, with the r0 rule taking final priority.
         always_comb begin
            val = rf_reg[addr];
            if (hit) val = bus.wr_data;
            if ((ZERO_R0 != 0) && (addr == '0)) val = '0;
         end

         assign bus.rd_data[data_lsb(gi, DATA_W) +: DATA_W] = val;
         assign bus.rd_busy[gi] = busy[addr] & ~hit;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic
// compared every cycle against an array-based model of the register file.
module tb_regfile_mp_sb;
   import regfile_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic CLK = 1'b0;
   logic Reset;
   always #5 CLK = ~CLK;

   regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus();

   regfile_mp_sb #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1), .BYPASS(1)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model: register contents and busy flags.
   logic [DW-1:0] rf_m   [32];
   bit            busy_m [32];
   bit            model_ok = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (bus.wr_en && bus.wr_addr == a && !Reset) return bus.wr_data;
      return rf_m[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      return busy_m[a] && !(bus.wr_en && bus.wr_addr == a && !Reset);
   endfunction

   function automatic logic [AW:0] exp_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(busy_m[i]);
      return AW'(0) + (AW+1)'(c);
   endfunction

   // Model update at the clock edge from the inputs the DUT sees.
   always @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) begin
            rf_m[i]   <= '0;
            busy_m[i] <= 1'b0;
         end
         model_ok <= 1'b1;
      end else begin
         if (bus.wr_en && bus.wr_addr != 0) begin
            rf_m[bus.wr_addr]   <= bus.wr_data;
            busy_m[bus.wr_addr] <= 1'b0;
         end
         if (bus.sb_set && bus.sb_set_addr != 0) busy_m[bus.sb_set_addr] <= 1'b1;
      end
   end

   // Every-cycle comparison, mid-cycle when inputs and outputs are stable.
   always @(negedge CLK) begin
      if (model_ok) begin
         for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            a = bus.rd_addr[p*AW +: AW];
            check($sformatf("cyc_rd_data%0d", p), bus.rd_data[p*DW +: DW], exp_rd(a));
            check($sformatf("cyc_rd_busy%0d", p), DW'(bus.rd_busy[p]), DW'(exp_busy(a)));
         end
         check("cyc_busy_cnt", DW'(bus.busy_cnt), DW'(exp_cnt()));
      end
   end

   task automatic set_in(input logic rst, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic ss, input logic [AW-1:0] sa,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      Reset           = rst;
      bus.wr_en       = we;
      bus.wr_addr     = wa;
      bus.wr_data     = wd;
      bus.sb_set      = ss;
      bus.sb_set_addr = sa;
      bus.rd_addr     = {a1, a0};
      $display("txn t=%0t rst=%0b we=%0b wa=%0d wd=%h ss=%0b sa=%0d a0=%0d a1=%0d",
               $time, rst, we, wa, wd, ss, sa, a0, a1);
   endtask

   task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, a0, a1);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, 31));
   endfunction

   initial begin
      set_in(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
      step();

      // 1: after reset every register reads zero and nothing is busy.
      for (int i = 0; i < 32; i++) begin
         idle(AW'(i), AW'(31 - i));
         #1;
         check("rst_rd0",  bus.rd_data[31:0],  32'h0);
         check("rst_rd1",  bus.rd_data[63:32], 32'h0);
         check("rst_busy", DW'(bus.rd_busy),   32'h0);
         check("rst_cnt",  DW'(bus.busy_cnt),  32'h0);
         step();
      end

      // 2: bypass in the write cycle, then array read on the other port.
      set_in(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd0);
      #1 check("bypass_r5", bus.rd_data[31:0], 32'hDEADBEEF);
      step();
      idle(5'd0, 5'd5);
      #1 check("array_r5", bus.rd_data[63:32], 32'hDEADBEEF);
      step();

      // 3: r0 ignores writes and issue.
      set_in(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
      #1;
      check("r0_bypass",  bus.rd_data[31:0], 32'h0);
      check("r0_busy",    DW'(bus.rd_busy),  32'h0);
      step();
      idle(5'd0, 5'd0);
      #1;
      check("r0_after",   bus.rd_data[31:0], 32'h0);
      check("r0_cnt",     DW'(bus.busy_cnt), 32'h0);
      step();

      // 4: two issues, then writeback of one.
      set_in(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd0, 5'd0); step();
      set_in(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0); step();
      idle(5'd3, 5'd7);
      #1;
      check("sb_cnt2",    DW'(bus.busy_cnt),   32'd2);
      check("sb_busy_r3", DW'(bus.rd_busy[0]), 32'd1);
      step();
      set_in(1'b0, 1'b1, 5'd3, 32'h55, 1'b0, '0, 5'd3, 5'd0);
      #1;
      check("wb_busy_r3", DW'(bus.rd_busy[0]), 32'd0);
      check("wb_data_r3", bus.rd_data[31:0],   32'h55);
      step();
      idle(5'd3, 5'd0);
      #1 check("wb_cnt1", DW'(bus.busy_cnt), 32'd1);
      step();

      // 5: set and write to the same busy register: set wins.
      set_in(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd0, 5'd0); step();
      set_in(1'b0, 1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 5'd0, 5'd0); step();
      idle(5'd9, 5'd0);
      #1;
      check("coll_data",  bus.rd_data[31:0],   32'hAA);
      check("coll_busy",  DW'(bus.rd_busy[0]), 32'd1);
      check("coll_cnt",   DW'(bus.busy_cnt),   32'd2);
      step();

      // 6: reset wins over a same-cycle write.
      for (int r = 1; r <= 4; r++) begin
         set_in(1'b0, 1'b0, '0, '0, 1'b1, AW'(r), 5'd0, 5'd0);
         step();
      end
      idle(5'd0, 5'd0);
      #1 check("pre_rst_cnt", DW'(bus.busy_cnt), 32'd6);
      step();
      set_in(1'b1, 1'b1, 5'd2, 32'hFF, 1'b0, '0, 5'd2, 5'd2);
      step();
      idle(5'd2, 5'd3);
      #1;
      check("rst_r2",   bus.rd_data[31:0], 32'h0);
      check("rst_cnt0", DW'(bus.busy_cnt), 32'd0);
      step();

      // Random traffic; the every-cycle compare process does the checking.
      for (int n = 0; n < 1500; n++) begin
         set_in(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 2) != 0), rnd_addr(), $urandom(),
                ($urandom_range(0, 1) == 1), rnd_addr(),
                rnd_addr(), rnd_addr());
         step();
      end

      idle(5'd0, 5'd0);
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
